// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow signal in clock cycles, with lock and timeout
module clock_period_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
    state_t state, state_n;
    logic s1, s2, s3;
    logic rise, fall, sat;
    logic [WIDTH-1:0] cnt, period_n, high_time_n;
    logic period_valid_n, locked_n, timeout_n;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign sat = cnt == {WIDTH{1'b1}};
    always_comb begin
        state_n = state;
        period_n = period;
        high_time_n = high_time;
        period_valid_n = 1'b0;
        locked_n = locked;
        timeout_n = timeout;
        if (state == IDLE) begin
            if (rise) begin
                state_n = MEASURE;
                timeout_n = 1'b0;
            end
        end else if (rise) begin
            period_n = cnt;
            period_valid_n = 1'b1;
            locked_n = 1'b1;
            state_n = LOCKED;
        end else if (sat) begin
            state_n = IDLE;
            timeout_n = 1'b1;
            locked_n = 1'b0;
            period_n = '0;
            high_time_n = '0;
        end else if (fall) begin
            high_time_n = cnt;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            cnt <= '0;
            state <= IDLE;
            period <= '0;
            high_time <= '0;
            period_valid <= 1'b0;
            locked <= 1'b0;
            timeout <= 1'b0;
        end else begin
            s1 <= signal_in;
            s2 <= s1;
            s3 <= s2;
            cnt <= rise ? WIDTH'(1) : sat ? cnt : cnt + WIDTH'(1);
            state <= state_n;
            period <= period_n;
            high_time <= high_time_n;
            period_valid <= period_valid_n;
            locked <= locked_n;
            timeout <= timeout_n;
        end
    end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: waveform table plus corner sequences, valid pulses checked against a queue of expected results
module tb_clock_period_meter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sig = 1'b0;
    logic sig4 = 1'b0;
    logic [15:0] period, high_time;
    logic period_valid, locked, timeout;
    logic [3:0] period4, high_time4;
    logic period_valid4, locked4, timeout4;
    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] period;
        logic [15:0] high;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int h;
        int l;
        int n;
        int exp_period;
        int exp_high;
    } rec_t;
    rec_t recs[5];

    logic prev_pv = 1'b0;

    clock_period_meter #(.WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .signal_in(sig),
        .period(period), .high_time(high_time),
        .period_valid(period_valid), .locked(locked), .timeout(timeout)
    );

    clock_period_meter #(.WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .signal_in(sig4),
        .period(period4), .high_time(high_time4),
        .period_valid(period_valid4), .locked(locked4), .timeout(timeout4)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (period_valid) begin
            check("valid_back_to_back", {31'b0, prev_pv}, 0);
            if (q.size() == 0) begin
                check("valid_without_expectation", {31'b0, period_valid}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("period_at_valid", {16'b0, period}, {16'b0, e.period});
                check("high_time_at_valid", {16'b0, high_time}, {16'b0, e.high});
            end
        end
        prev_pv <= period_valid;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        sig = 1'b0;
        sig4 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive(input int h, input int l);
        sig = 1'b1;
        repeat (h) @(negedge clock);
        sig = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        e.period = 16'(p);
        e.high = 16'(h);
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clock);
        check(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        recs[0] = '{h: 8, l: 8, n: 4, exp_period: 16, exp_high: 8};
        recs[1] = '{h: 1, l: 1, n: 6, exp_period: 2, exp_high: 1};
        recs[2] = '{h: 3, l: 13, n: 2, exp_period: 16, exp_high: 3};
        recs[3] = '{h: 10, l: 10, n: 2, exp_period: 20, exp_high: 10};
        recs[4] = '{h: 5, l: 2, n: 3, exp_period: 7, exp_high: 5};

        do_reset();
        check("reset_period", {16'b0, period}, 0);
        check("reset_high_time", {16'b0, high_time}, 0);
        check("reset_valid", {31'b0, period_valid}, 0);
        check("reset_locked", {31'b0, locked}, 0);
        check("reset_timeout", {31'b0, timeout}, 0);

        foreach (recs[i]) begin
            do_reset();
            for (int k = 0; k < recs[i].n; k++) push(recs[i].exp_period, recs[i].exp_high);
            for (int k = 0; k <= recs[i].n; k++) drive(recs[i].h, recs[i].l);
            drain("missed_valid");
            check("locked_after_table", {31'b0, locked}, 1);
            check("period_held", {16'b0, period}, recs[i].exp_period);
        end

        // duty cycle change from 3/13 to 12/4 keeps the period at 16
        do_reset();
        repeat (3) push(16, 3);
        repeat (3) drive(3, 13);
        sig = 1'b1;
        repeat (12) @(negedge clock);
        check("duty_high_before_fall", {16'b0, high_time}, 3);
        sig = 1'b0;
        repeat (4) @(negedge clock);
        check("duty_high_after_fall", {16'b0, high_time}, 12);
        check("duty_period_kept", {16'b0, period}, 16);
        push(16, 12);
        drive(12, 4);
        drain("duty_missed_valid");

        // reset during the low phase discards the partial measurement
        do_reset();
        sig = 1'b1;
        repeat (10) @(negedge clock);
        sig = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("reset_mid_locked", {31'b0, locked}, 0);
        drive(10, 10);
        push(20, 10);
        drive(10, 10);
        drain("reset_mid_missed_valid");

        // narrow meter: period equal to saturation, then timeout and recovery
        do_reset();
        sig4 = 1'b1;
        repeat (4) @(negedge clock);
        sig4 = 1'b0;
        repeat (4) @(negedge clock);
        sig4 = 1'b1;
        repeat (3) @(negedge clock);
        check("w4_valid_first", {31'b0, period_valid4}, 1);
        check("w4_period_first", {28'b0, period4}, 8);
        check("w4_high_first", {28'b0, high_time4}, 4);
        check("w4_locked_first", {31'b0, locked4}, 1);
        repeat (2) @(negedge clock);
        sig4 = 1'b0;
        repeat (10) @(negedge clock);
        sig4 = 1'b1;
        repeat (3) @(negedge clock);
        check("w4_valid_sat", {31'b0, period_valid4}, 1);
        check("w4_period_sat", {28'b0, period4}, 15);
        check("w4_timeout_sat", {31'b0, timeout4}, 0);
        repeat (2) @(negedge clock);
        sig4 = 1'b0;
        repeat (12) @(negedge clock);
        check("w4_timeout_early", {31'b0, timeout4}, 0);
        check("w4_locked_early", {31'b0, locked4}, 1);
        @(negedge clock);
        check("w4_timeout", {31'b0, timeout4}, 1);
        check("w4_locked_timeout", {31'b0, locked4}, 0);
        check("w4_period_timeout", {28'b0, period4}, 0);
        check("w4_high_timeout", {28'b0, high_time4}, 0);
        repeat (3) @(negedge clock);
        sig4 = 1'b1;
        repeat (2) @(negedge clock);
        check("w4_timeout_held", {31'b0, timeout4}, 1);
        @(negedge clock);
        check("w4_timeout_cleared", {31'b0, timeout4}, 0);
        check("w4_no_valid_idle_rise", {31'b0, period_valid4}, 0);
        check("w4_unlocked_measure", {31'b0, locked4}, 0);
        repeat (2) @(negedge clock);
        sig4 = 1'b0;
        repeat (3) @(negedge clock);
        sig4 = 1'b1;
        repeat (3) @(negedge clock);
        check("w4_valid_recover", {31'b0, period_valid4}, 1);
        check("w4_period_recover", {28'b0, period4}, 8);
        check("w4_high_recover", {28'b0, high_time4}, 5);
        check("w4_locked_recover", {31'b0, locked4}, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, bit width of the cycle counter and of every measurement output.
REQ-002 SHALL have port: clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: signal_in  input  1  asynchronous slow toggling signal to measure, e.g. a divided clock.
REQ-005 SHALL have port: period  output  WIDTH  clock cycles between the last two detected rising edges of signal_in.
REQ-006 SHALL have port: high_time  output  WIDTH  clock cycles from the last detected rising edge to the following falling edge.
REQ-007 SHALL have port: period_valid  output  1  one-cycle pulse when period has just been updated.
REQ-008 SHALL have port: locked  output  1  level; high while at least one full period has been measured and no timeout has occurred since.
REQ-009 SHALL have port: timeout  output  1  level; high after the counter saturates without a rising edge.

Function
REQ-010 SHALL pass signal_in through a 3-flop chain s1<=signal_in, s2<=s1, s3<=s2, all cleared by reset.
REQ-011 SHALL define rise = s2 & !s3 and fall = !s2 & s3; rise and fall are mutually exclusive by construction.
REQ-012 SHALL register every output; a signal_in transition sampled at clock edge k is reflected in outputs after clock edge k+2.
REQ-013 SHALL have a WIDTH-bit counter cnt: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at 2^WIDTH-1.
REQ-014 SHALL implement FSM states IDLE, MEASURE and LOCKED, with reset state IDLE.
REQ-015 IDLE: on rise, go to MEASURE and clear timeout; fall is ignored; period_valid stays 0.
REQ-016 MEASURE: on fall, high_time<=cnt; on rise, period<=cnt, period_valid<=1, locked<=1, and go to LOCKED.
REQ-017 LOCKED: on fall, high_time<=cnt; on rise, period<=cnt and period_valid<=1.
REQ-018 SHALL deassert period_valid in every cycle without a rise in MEASURE or LOCKED, so it is never high for two consecutive cycles.
REQ-019 Saturation in MEASURE or LOCKED (cnt = 2^WIDTH-1 and no rise): go to IDLE, timeout<=1, locked<=0, period<=0, high_time<=0; no period_valid.
REQ-020 timeout SHALL remain high until the next rise and clear in the cycle that rise is processed.
REQ-021 A rise in the same cycle cnt reaches saturation SHALL take precedence, i.e. a normal measurement with period = 2^WIDTH-1.
REQ-022 Minimum measurable period SHALL be 2 cycles (signal_in toggling every clock); no edge may be missed at that rate.
REQ-023 period and high_time SHALL hold their last values between updates.

Reset
REQ-024 reset SHALL take priority over all other behaviour and act synchronously at the clock edge.
REQ-025 reset SHALL force: s1..s3=0, cnt=0, state=IDLE, period=0, high_time=0, period_valid=0, locked=0, timeout=0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; the first rise after release is treated as the IDLE first edge.

Verification
REQ-027 WIDTH=16, signal_in 8 cycles high / 8 cycles low -> after second rise: period=16, high_time=8, one period_valid pulse per 16 cycles, locked=1.
REQ-028 signal_in toggling every cycle -> period=2, high_time=1, period_valid pulsing every 2nd cycle, no missed edges.
REQ-029 WIDTH=4, signal_in held low after lock -> timeout=1, locked=0, period=0 exactly 15 cycles after the last processed rise; next rise clears timeout, state MEASURE.
REQ-030 Reset pulsed between two rises of a 10/10 waveform -> no period_valid at the next rise; first valid period=20 at the rise after that.
REQ-031 Duty change from 3/13 to 12/4 cycles -> high_time updates from 3 to 12 at the fall, period stays 16, no spurious period_valid.
